// File: rtl/decode_stage_if.sv
// Decode-stage bundle: write-back, hazard inputs, and the control/operand outputs.
// The decode stage is the slave; the surrounding pipeline is the master.
interface decode_stage_if;
    logic [31:0] InstrD;
    logic        RegWriteW;
    logic [4:0]  WriteRegW;
    logic [31:0] ResultW;
    logic        MemtoRegE;
    logic [4:0]  RtE;
    logic        ClrErr;

    logic        RegWriteD;
    logic        MemtoRegD;
    logic        MemWriteD;
    logic        ALUSrcD;
    logic        RegDstD;
    logic [2:0]  ALUControlD;
    logic        BranchD;
    logic        JumpD;
    logic [31:0] Op1D;
    logic [31:0] Op2D;
    logic [4:0]  RsD;
    logic [4:0]  RtD;
    logic [4:0]  RdD;
    logic [15:0] SignImmD;
    logic        StallD;
    logic        FlushE;
    logic        IllegalFlag;

    modport master (
        output InstrD, RegWriteW, WriteRegW, ResultW, MemtoRegE, RtE, ClrErr,
        input  RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD, ALUControlD,
               BranchD, JumpD, Op1D, Op2D, RsD, RtD, RdD, SignImmD,
               StallD, FlushE, IllegalFlag
    );

    modport slave (
        input  InstrD, RegWriteW, WriteRegW, ResultW, MemtoRegE, RtE, ClrErr,
        output RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD, ALUControlD,
               BranchD, JumpD, Op1D, Op2D, RsD, RtD, RdD, SignImmD,
               StallD, FlushE, IllegalFlag
    );
endinterface

// File: rtl/decode_stage.sv
// MIPS decode stage: 32x32 register file with write-through bypass, main/funct
// decoder, load-use hazard detection and a sticky illegal-instruction flag.
module decode_stage (
    input  logic                 CLK_Dec,
    input  logic                 RST_Dec,
    decode_stage_if.slave        bus
);

    logic [31:0] r_rf [32];
    logic        r_illegal;

    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic        w_wr_en;
    logic        w_stall;
    logic        w_illegal;

    logic        w_reg_write;
    logic        w_mem_to_reg;
    logic        w_mem_write;
    logic        w_alu_src;
    logic        w_reg_dst;
    logic [2:0]  w_alu_ctl;
    logic        w_branch;
    logic        w_jump;
    logic [31:0] w_op1;
    logic [31:0] w_op2;

    assign w_op    = bus.InstrD[31:26];
    assign w_funct = bus.InstrD[5:0];
    assign w_rs    = bus.InstrD[25:21];
    assign w_rt    = bus.InstrD[20:16];
    assign w_wr_en = bus.RegWriteW && (bus.WriteRegW != 5'd0);

    always_ff @(posedge CLK_Dec or negedge RST_Dec) begin
        if (!RST_Dec) begin
            for (int i = 0; i < 32; i++) r_rf[i] <= '0;
        end else if (w_wr_en) begin
            r_rf[bus.WriteRegW] <= bus.ResultW;
        end
    end

    // Bypass is gated by reset too, so a read during reset is 0 even if a write is pending.
    always_comb begin
        w_op1 = '0;
        w_op2 = '0;
        if (RST_Dec && w_rs != 5'd0)
            w_op1 = (w_wr_en && bus.WriteRegW == w_rs) ? bus.ResultW : r_rf[w_rs];
        if (RST_Dec && w_rt != 5'd0)
            w_op2 = (w_wr_en && bus.WriteRegW == w_rt) ? bus.ResultW : r_rf[w_rt];
    end

    always_comb begin
        w_reg_write  = 1'b0;
        w_mem_to_reg = 1'b0;
        w_mem_write  = 1'b0;
        w_alu_src    = 1'b0;
        w_reg_dst    = 1'b0;
        w_alu_ctl    = 3'b000;
        w_branch     = 1'b0;
        w_jump       = 1'b0;
        w_illegal    = 1'b0;
        case (w_op)
            6'b000000: begin
                // All-zero word is the canonical NOP, not an unknown funct.
                if (bus.InstrD != 32'd0) begin
                    w_reg_write = 1'b1;
                    w_reg_dst   = 1'b1;
                    case (w_funct)
                        6'b100000: w_alu_ctl = 3'b010;
                        6'b100010: w_alu_ctl = 3'b110;
                        6'b100100: w_alu_ctl = 3'b000;
                        6'b100101: w_alu_ctl = 3'b001;
                        6'b101010: w_alu_ctl = 3'b111;
                        default: begin
                            w_reg_write = 1'b0;
                            w_illegal   = 1'b1;
                        end
                    endcase
                end
            end
            6'b100011: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
                w_alu_src    = 1'b1;
                w_alu_ctl    = 3'b010;
            end
            6'b101011: begin
                w_mem_write = 1'b1;
                w_alu_src   = 1'b1;
                w_alu_ctl   = 3'b010;
            end
            6'b000100: begin
                w_branch  = 1'b1;
                w_alu_ctl = 3'b110;
            end
            6'b001000: begin
                w_reg_write = 1'b1;
                w_alu_src   = 1'b1;
                w_alu_ctl   = 3'b010;
            end
            6'b000010: w_jump = 1'b1;
            default:   w_illegal = 1'b1;
        endcase
    end

    assign w_stall = bus.MemtoRegE && (bus.RtE != 5'd0) &&
                     ((bus.RtE == w_rs) || (bus.RtE == w_rt));

    // A stalled instruction is re-decoded next cycle, so it only flags once it proceeds.
    always_ff @(posedge CLK_Dec or negedge RST_Dec) begin
        if (!RST_Dec)                   r_illegal <= 1'b0;
        else if (w_illegal && !w_stall) r_illegal <= 1'b1;
        else if (bus.ClrErr)            r_illegal <= 1'b0;
    end

    assign bus.RegWriteD   = w_reg_write;
    assign bus.MemtoRegD   = w_mem_to_reg;
    assign bus.MemWriteD   = w_mem_write;
    assign bus.ALUSrcD     = w_alu_src;
    assign bus.RegDstD     = w_reg_dst;
    assign bus.ALUControlD = w_alu_ctl;
    assign bus.BranchD     = w_branch;
    assign bus.JumpD       = w_jump;
    assign bus.Op1D        = w_op1;
    assign bus.Op2D        = w_op2;
    assign bus.RsD         = w_rs;
    assign bus.RtD         = w_rt;
    assign bus.RdD         = bus.InstrD[15:11];
    assign bus.SignImmD    = bus.InstrD[15:0];
    assign bus.StallD      = w_stall;
    assign bus.FlushE      = w_stall;
    assign bus.IllegalFlag = r_illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed plus random vectors, expected
// outputs from an ISA-level reference model, checked by a separate monitor.
module tb_decode_stage;

    logic clk;
    logic rst_n;
    decode_stage_if bus();

    decode_stage dut (.CLK_Dec(clk), .RST_Dec(rst_n), .bus(bus.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  ctrl;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [30:0] fld;
        logic [1:0]  hz;
        logic        ill;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] m_rf [32];
    logic        m_flag;
    int          n_vec;
    int          n_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode from the ISA table: returns {illegal, RegW, MtoR, MemW, ALUSrc, RegDst, ALU[2:0], Br, J}.
    function automatic logic [10:0] ref_dec(input logic [31:0] ins);
        logic rw, mr, mw, as, rd, br, j, il;
        logic [2:0] alu;
        {rw, mr, mw, as, rd, br, j, il} = '0;
        alu = 3'b000;
        if (ins == 32'd0) begin
            il = 1'b0;
        end else if (ins[31:26] == 6'd0) begin
            rd = 1'b1;
            rw = 1'b1;
            if      (ins[5:0] == 6'h20) alu = 3'b010;
            else if (ins[5:0] == 6'h22) alu = 3'b110;
            else if (ins[5:0] == 6'h24) alu = 3'b000;
            else if (ins[5:0] == 6'h25) alu = 3'b001;
            else if (ins[5:0] == 6'h2a) alu = 3'b111;
            else begin rw = 1'b0; il = 1'b1; end
        end else if (ins[31:26] == 6'h23) begin rw = 1; mr = 1; as = 1; alu = 3'b010; end
        else if (ins[31:26] == 6'h2b) begin mw = 1; as = 1; alu = 3'b010; end
        else if (ins[31:26] == 6'h04) begin br = 1; alu = 3'b110; end
        else if (ins[31:26] == 6'h08) begin rw = 1; as = 1; alu = 3'b010; end
        else if (ins[31:26] == 6'h02) j = 1;
        else il = 1'b1;
        return {il, rw, mr, mw, as, rd, alu, br, j};
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] a, input logic rst,
                                             input logic we, input logic [4:0] wa,
                                             input logic [31:0] wd);
        if (!rst || a == 5'd0) return 32'd0;
        if (we && wa == a && wa != 5'd0) return wd;
        return m_rf[a];
    endfunction

    // Drive one vector mid-cycle, predict the response, then advance the model past the next edge.
    task automatic apply(input logic [31:0] ins, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic me, input logic [4:0] rte,
                         input logic clr, input logic rst);
        exp_t e;
        logic [10:0] d;
        logic [4:0] rs, rt;
        @(posedge clk);
        #1;
        bus.InstrD = ins; bus.RegWriteW = we; bus.WriteRegW = wa; bus.ResultW = wd;
        bus.MemtoRegE = me; bus.RtE = rte; bus.ClrErr = clr; rst_n = rst;
        rs = ins[25:21];
        rt = ins[20:16];
        if (!rst) begin
            for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
            m_flag = 1'b0;
        end
        d = ref_dec(ins);
        e.ctrl = d[9:0];
        e.op1  = ref_read(rs, rst, we, wa, wd);
        e.op2  = ref_read(rt, rst, we, wa, wd);
        e.fld  = {rs, rt, ins[15:11], ins[15:0]};
        e.hz   = {2{me && rte != 5'd0 && (rte == rs || rte == rt)}};
        e.ill  = m_flag;
        sb_q.push_back(e);
        if (rst) begin
            if (we && wa != 5'd0) m_rf[wa] = wd;
            if (d[10] && !e.hz[0]) m_flag = 1'b1;
            else if (clr)          m_flag = 1'b0;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("ctrl", {22'd0, bus.RegWriteD, bus.MemtoRegD, bus.MemWriteD, bus.ALUSrcD,
                             bus.RegDstD, bus.ALUControlD, bus.BranchD, bus.JumpD}, {22'd0, e.ctrl});
                chk("Op1D", bus.Op1D, e.op1);
                chk("Op2D", bus.Op2D, e.op2);
                chk("fields", {1'b0, bus.RsD, bus.RtD, bus.RdD, bus.SignImmD}, {1'b0, e.fld});
                chk("stall_flush", {30'd0, bus.StallD, bus.FlushE}, {30'd0, e.hz});
                chk("IllegalFlag", {31'd0, bus.IllegalFlag}, {31'd0, e.ill});
            end
        end
    end

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'd0, rs, rt, rd, 5'd0, fn};
    endfunction

    initial begin : stim
        logic [5:0] ops [6];
        logic [5:0] fns [5];
        logic [31:0] ins;
        int sel;
        ops = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h08, 6'h02};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
        n_vec = 0; n_err = 0; m_flag = 1'b0;
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        bus.InstrD = '0; bus.RegWriteW = 0; bus.WriteRegW = '0; bus.ResultW = '0;
        bus.MemtoRegE = 0; bus.RtE = '0; bus.ClrErr = 0;
        rst_n = 1'b0;

        // Reset state, including a write attempt that must be ignored.
        apply(rtype(5'd1, 5'd2, 5'd3, 6'h20), 1, 5'd1, 32'hAAAA5555, 0, 0, 0, 0);
        for (int i = 1; i < 32; i++)
            apply(rtype(5'(i), 5'(i), 5'd0, 6'h20), 0, 0, 0, 0, 0, 0, 1);
        // $0 is never written.
        apply(rtype(5'd0, 5'd0, 5'd1, 6'h20), 1, 5'd0, 32'hDEADBEEF, 0, 0, 0, 1);
        apply(rtype(5'd0, 5'd0, 5'd1, 6'h20), 0, 0, 0, 0, 0, 0, 1);
        // Bypass then storage.
        apply(rtype(5'd5, 5'd0, 5'd1, 6'h20), 1, 5'd5, 32'h12345678, 0, 0, 0, 1);
        apply(rtype(5'd5, 5'd0, 5'd1, 6'h20), 0, 0, 0, 0, 0, 0, 1);
        // lw $8,4($9)
        apply(32'h8D280004, 0, 0, 0, 0, 0, 0, 1);
        // Load-use with RtE=8, then RtE=0.
        apply(rtype(5'd8, 5'd3, 5'd10, 6'h20), 0, 0, 0, 1, 5'd8, 0, 1);
        apply(rtype(5'd8, 5'd3, 5'd10, 6'h20), 0, 0, 0, 1, 5'd0, 0, 1);
        apply(rtype(5'd2, 5'd8, 5'd10, 6'h20), 0, 0, 0, 1, 5'd8, 0, 1);
        // Stalled illegal must not set the flag.
        apply(rtype(5'd8, 5'd2, 5'd3, 6'h3f), 0, 0, 0, 1, 5'd8, 0, 1);
        // Illegal funct, hold, clear.
        apply(rtype(5'd1, 5'd2, 5'd3, 6'h3f), 0, 0, 0, 0, 0, 0, 1);
        apply(32'h00000000, 0, 0, 0, 0, 0, 0, 1);
        apply(32'h00000000, 0, 0, 0, 0, 0, 0, 1);
        apply(rtype(5'd1, 5'd2, 5'd3, 6'h20), 0, 0, 0, 0, 0, 1, 1);
        apply(32'h00000000, 0, 0, 0, 0, 0, 0, 1);
        // Set beats clear in the same cycle.
        apply(32'hFC000000, 0, 0, 0, 0, 0, 1, 1);
        apply(32'h00000000, 0, 0, 0, 0, 0, 1, 1);
        apply(32'h00000000, 0, 0, 0, 0, 0, 0, 1);
        // Write $3, then reset mid-cycle: read of $3 is 0 immediately.
        apply(32'h00000000, 1, 5'd3, 32'hCAFEF00D, 0, 0, 0, 1);
        apply(rtype(5'd3, 5'd3, 5'd0, 6'h20), 0, 0, 0, 0, 0, 0, 1);
        apply(rtype(5'd3, 5'd3, 5'd0, 6'h20), 0, 0, 0, 0, 0, 0, 0);
        apply(rtype(5'd3, 5'd3, 5'd0, 6'h20), 1, 5'd3, 32'h0BADF00D, 0, 0, 0, 1);
        apply(rtype(5'd3, 5'd3, 5'd0, 6'h20), 0, 0, 0, 0, 0, 0, 1);

        for (int n = 0; n < 600; n++) begin
            sel = $urandom_range(0, 8);
            ins = $urandom;
            ins[25:21] = 5'($urandom_range(0, 7));
            ins[20:16] = 5'($urandom_range(0, 7));
            if (sel < 6) ins[31:26] = ops[sel];
            else if (sel == 8) ins = 32'd0;
            if (sel == 0 && $urandom_range(0, 3) != 0) ins[5:0] = fns[$urandom_range(0, 4)];
            apply(ins, 1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom), 5'($urandom_range(0, 7)), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 60) != 0));
        end

        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
